// File: rtl/approx_mult_trunc_pipe.sv
// ============================================================================
// Module  : approx_mult_trunc_pipe
// Brief   : Pipelined unsigned truncated multiplier with valid/ready streaming
//           and a per-beat exact/approximate mode select. Define the macro
//           APPROX_MULT_COMP_EN to add single-bit error compensation in
//           approximate mode.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module approx_mult_trunc_pipe #(
    parameter int WIDTH  = 32,
    parameter int TRUNC  = 10,
    parameter int STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   x,
    input  logic [WIDTH-1:0]   y,
    input  logic               mode_exact,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] z
);

    localparam int c_PW = 2*WIDTH - TRUNC;
    localparam int c_ZW = 2*WIDTH;

    logic [WIDTH-TRUNC-1:0] w_x_hi;
    logic [c_PW-1:0]        w_prod_hi;
    logic [c_ZW-1:0]        w_z_exact;
    logic [c_ZW-1:0]        w_z_approx;
    logic [c_ZW-1:0]        w_z_next;
    logic [STAGES-1:0]      w_go;
    logic [STAGES-1:0]      r_v;
    logic [c_ZW-1:0]        r_z [STAGES];

    // The whole product is formed before slot 0; later slots only carry it.
    assign w_x_hi    = x[WIDTH-1:TRUNC];
    assign w_prod_hi = c_PW'(y) * c_PW'(w_x_hi);
    assign w_z_exact = c_ZW'(x) * c_ZW'(y);

`ifdef APPROX_MULT_COMP_EN
    logic w_comp_bit;
    assign w_comp_bit = x[2] & x[3] & y[TRUNC] & y[TRUNC-1];
    assign w_z_approx = {w_prod_hi, {TRUNC{1'b0}}} + (c_ZW'(w_comp_bit) << (TRUNC + 3));
`else
    assign w_z_approx = {w_prod_hi, {TRUNC{1'b0}}};
`endif

    assign w_z_next = mode_exact ? w_z_exact : w_z_approx;

    // Slot k may move on if any downstream slot is empty or the sink is taking data.
    assign w_go[STAGES-1] = out_ready;
    generate
        for (genvar k = 0; k < STAGES - 1; k++) begin : g_go
            assign w_go[k] = out_ready || !(&r_v[STAGES-1:k+1]);
        end
    endgenerate

    assign in_ready = !r_v[0] || w_go[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v <= '0;
            for (int k = 0; k < STAGES; k++) begin
                r_z[k] <= '0;
            end
        end else begin
            if (in_ready) begin
                r_v[0] <= in_valid;
                if (in_valid) begin
                    r_z[0] <= w_z_next;
                end
            end
            for (int k = 1; k < STAGES; k++) begin
                if (!r_v[k] || w_go[k]) begin
                    r_v[k] <= r_v[k-1];
                    if (r_v[k-1]) begin
                        r_z[k] <= r_z[k-1];
                    end
                end
            end
        end
    end

    assign out_valid = r_v[STAGES-1];
    assign z         = r_z[STAGES-1];

endmodule

`default_nettype wire
